// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR engine: operating modes and the
// saturating mismatch-count helper.
package lfsr_pkg;

   typedef enum logic [1:0] {
      MODE_GEN = 2'd0,
      MODE_CRC = 2'd1,
      MODE_SCR = 2'd2,
      MODE_CHK = 2'd3
   } lfsr_mode_e;

   // Adds the number of set bits in 'bits' to 'cnt', clamping at 2^cnt_w-1.
   function automatic logic [31:0] sat_add_pop(input logic [31:0] cnt,
                                               input logic [31:0] bits,
                                               input int unsigned cnt_w);
      logic [32:0] sum;
      logic [32:0] max;
      sum = {1'b0, cnt};
      for (int i = 0; i < 32; i++) begin
         sum = sum + {32'd0, bits[i]};
      end
      max = (33'd1 << cnt_w) - 33'd1;
      if (sum > max) begin
         sum = max;
      end
      return sum[31:0];
   endfunction

endpackage

// File: rtl/lfsr_step.sv
// One Galois LFSR bit step, MSB first: the outgoing bit is the register MSB
// and the feedback (MSB xor input bit) applies the polynomial taps.
module lfsr_step #(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] POLY  = WIDTH'(32'h1021)
)(
   input  logic [WIDTH-1:0] i_state,
   input  logic             i_b,
   output logic [WIDTH-1:0] o_next,
   output logic             o_bit
);

   logic w_fb;

   assign o_bit  = i_state[WIDTH-1];
   assign w_fb   = o_bit ^ i_b;
   assign o_next = {i_state[WIDTH-2:0], 1'b0} ^ (w_fb ? POLY : '0);

endmodule

// File: rtl/lfsr_engine.sv
// Parametrised Galois LFSR engine: PRBS generate, CRC accumulate, additive
// scramble and PRBS check, with all-zero lockup recovery.
module lfsr_engine
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] POLY  = WIDTH'(32'h1021),
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(32'hFFFF),
   parameter int               STEP  = 1,
   parameter int               CNT_W = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] seed_in,
   input  logic [1:0]       mode,
   input  logic [STEP-1:0]  din,
   output logic [STEP-1:0]  dout,
   output logic             dout_valid,
   output logic [WIDTH-1:0] state,
   output logic             lockup,
   output logic [CNT_W-1:0] err_cnt
);

   if (SEED == '0) begin : g_bad_seed
      $error("lfsr_engine: SEED must be nonzero");
   end
   if (POLY[0] != 1'b1) begin : g_bad_poly
      $error("lfsr_engine: POLY[0] must be 1");
   end
   if (WIDTH < 2 || WIDTH > 32 || STEP < 1 || STEP > WIDTH) begin : g_bad_size
      $error("lfsr_engine: WIDTH must be 2..32 and STEP 1..WIDTH");
   end

   lfsr_mode_e       w_mode;
   logic [STEP-1:0]  w_dout;
   logic [STEP-1:0]  w_mism;
   logic [WIDTH-1:0] w_step_state;
   logic             w_lock_hit;

   logic [WIDTH-1:0] r_state;
   logic [STEP-1:0]  r_dout;
   logic             r_dout_valid;
   logic             r_lockup;
   logic [CNT_W-1:0] r_err_cnt;

   assign w_mode = lfsr_mode_e'(mode);

   // Step k consumes din[STEP-1-k] and produces dout[STEP-1-k]; each stage
   // keeps its own next-state net so the chain is a plain feed-forward path.
   for (genvar k = 0; k < STEP; k++) begin : g_step
      logic [WIDTH-1:0] w_cur;
      logic [WIDTH-1:0] w_next;
      logic             w_din;
      logic             w_b;
      logic             w_o;

      if (k == 0) begin : g_first
         assign w_cur = r_state;
      end else begin : g_rest
         assign w_cur = g_step[k-1].w_next;
      end

      assign w_din = din[STEP-1-k];
      assign w_b   = (w_mode == MODE_CRC) & w_din;

      lfsr_step #(
         .WIDTH (WIDTH),
         .POLY  (POLY)
      ) u_step (
         .i_state (w_cur),
         .i_b     (w_b),
         .o_next  (w_next),
         .o_bit   (w_o)
      );

      assign w_dout[STEP-1-k] = (w_mode == MODE_SCR) ? (w_din ^ w_o) : w_o;
      assign w_mism[STEP-1-k] = (w_mode == MODE_CHK) & (w_din ^ w_o);
   end

   assign w_step_state = g_step[STEP-1].w_next;

   // A zero register is a legal CRC remainder; only the PRBS-style modes lock.
   assign w_lock_hit = en && (r_state == '0) && (w_mode != MODE_CRC);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= SEED;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_lockup     <= 1'b0;
         r_err_cnt    <= '0;
      end else if (load) begin
         r_state      <= seed_in;
         r_dout_valid <= 1'b0;
         r_lockup     <= 1'b0;
         r_err_cnt    <= '0;
      end else if (w_lock_hit) begin
         r_state      <= SEED;
         r_dout_valid <= 1'b0;
         r_lockup     <= 1'b1;
      end else if (en) begin
         r_state      <= w_step_state;
         r_dout       <= w_dout;
         r_dout_valid <= 1'b1;
         r_lockup     <= 1'b0;
         if (w_mode == MODE_CHK) begin
            r_err_cnt <= CNT_W'(sat_add_pop(32'(r_err_cnt), 32'(w_mism), CNT_W));
         end
      end else begin
         r_dout_valid <= 1'b0;
         r_lockup     <= 1'b0;
      end
   end

   assign state      = r_state;
   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign lockup     = r_lockup;
   assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_lfsr_engine.sv
// Self-checking bench for lfsr_engine: directed vector table on a 4-bit
// instance, CRC/lockup/scramble sequences and a randomized reference-model run.
module tb_lfsr_engine;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // 4-bit instance: x^4+x+1, seed 0001, one bit per cycle, 4-bit counter
   logic       a_en = 0, a_load = 0, a_din = 0;
   logic [3:0] a_seed = '0;
   logic [1:0] a_mode = '0;
   logic       a_dout, a_valid, a_lock;
   logic [3:0] a_state, a_err;

   lfsr_engine #(.WIDTH(4), .POLY(4'h3), .SEED(4'h1), .STEP(1), .CNT_W(4)) u_a (
      .clk(clk), .rst(rst), .en(a_en), .load(a_load), .seed_in(a_seed),
      .mode(a_mode), .din(a_din), .dout(a_dout), .dout_valid(a_valid),
      .state(a_state), .lockup(a_lock), .err_cnt(a_err));

   // 16-bit CCITT instance, byte per cycle
   logic        b_en = 0, b_load = 0;
   logic [15:0] b_seed = '0;
   logic [1:0]  b_mode = '0;
   logic [7:0]  b_din = '0;
   logic [7:0]  b_dout;
   logic        b_valid, b_lock;
   logic [15:0] b_state, b_err;

   lfsr_engine #(.WIDTH(16), .POLY(16'h1021), .SEED(16'hFFFF), .STEP(8), .CNT_W(16)) u_b (
      .clk(clk), .rst(rst), .en(b_en), .load(b_load), .seed_in(b_seed),
      .mode(b_mode), .din(b_din), .dout(b_dout), .dout_valid(b_valid),
      .state(b_state), .lockup(b_lock), .err_cnt(b_err));

   // 16-bit instance, nibble per cycle, used as scrambler
   logic        c_en = 0, c_load = 0;
   logic [15:0] c_seed = '0;
   logic [1:0]  c_mode = '0;
   logic [3:0]  c_din = '0;
   logic [3:0]  c_dout;
   logic        c_valid, c_lock;
   logic [15:0] c_state, c_err;

   lfsr_engine #(.WIDTH(16), .POLY(16'h1021), .SEED(16'hFFFF), .STEP(4), .CNT_W(16)) u_c (
      .clk(clk), .rst(rst), .en(c_en), .load(c_load), .seed_in(c_seed),
      .mode(c_mode), .din(c_din), .dout(c_dout), .dout_valid(c_valid),
      .state(c_state), .lockup(c_lock), .err_cnt(c_err));

   typedef struct {
      logic       ld;
      logic       en;
      logic [1:0] md;
      logic [3:0] sd;
      logic       di;
      logic [3:0] e_state;
      logic       e_dout;
      logic       e_valid;
      logic       e_lock;
      logic [3:0] e_err;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic ld, input logic en, input logic [1:0] md,
                               input logic [3:0] sd, input logic di, input logic [3:0] es,
                               input logic ed, input logic ev, input logic el,
                               input logic [3:0] ee);
      vec_t v;
      v.ld = ld; v.en = en; v.md = md; v.sd = sd; v.di = di;
      v.e_state = es; v.e_dout = ed; v.e_valid = ev; v.e_lock = el; v.e_err = ee;
      return v;
   endfunction

   // Reference: multiply the register polynomial by x modulo the generator,
   // folding in input bit b; o is the coefficient shifted out.
   function automatic int unsigned mstep(input int unsigned s, input int w,
                                         input int unsigned poly, input bit b,
                                         output bit o);
      int unsigned mask;
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      o = ((s >> (w - 1)) & 32'd1) != 0;
      return ((s << 1) & mask) ^ ((o ^ b) ? poly : 32'd0);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0]  gseq [15];
      logic        gdo  [15];
      logic [15:0] visited;
      int unsigned ms;
      bit          o;
      logic [31:0] pat, scr, rec;
      logic [3:0]  exp_nib;
      logic [15:0] m_st;
      logic [7:0]  m_dout;
      logic        m_valid, m_lock;
      int unsigned m_err;

      gseq = '{4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB, 4'h5,
               4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1};
      gdo  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
               1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

      // ld en md sd di | state dout valid lock err
      tbl.push_back(mk(1, 0, 0, 4'h1, 0, 4'h1, 0, 0, 0, 4'h0));
      for (int k = 0; k < 15; k++)
         tbl.push_back(mk(0, 1, 0, 4'h0, 0, gseq[k], gdo[k], 1, 0, 4'h0));
      tbl.push_back(mk(0, 0, 0, 4'h0, 0, 4'h1, 1, 0, 0, 4'h0));
      tbl.push_back(mk(1, 1, 0, 4'h5, 0, 4'h5, 1, 0, 0, 4'h0));
      tbl.push_back(mk(1, 0, 0, 4'h0, 0, 4'h0, 1, 0, 0, 4'h0));
      tbl.push_back(mk(0, 1, 0, 4'h0, 0, 4'h1, 1, 0, 1, 4'h0));
      tbl.push_back(mk(0, 1, 0, 4'h0, 0, 4'h2, 0, 1, 0, 4'h0));
      tbl.push_back(mk(0, 1, 3, 4'h0, 0, 4'h4, 0, 1, 0, 4'h0));
      tbl.push_back(mk(0, 1, 3, 4'h0, 0, 4'h8, 0, 1, 0, 4'h0));
      tbl.push_back(mk(0, 1, 3, 4'h0, 0, 4'h3, 1, 1, 0, 4'h1));
      tbl.push_back(mk(0, 1, 1, 4'h0, 1, 4'h5, 0, 1, 0, 4'h1));
      tbl.push_back(mk(0, 1, 2, 4'h0, 1, 4'hA, 1, 1, 0, 4'h1));
      tbl.push_back(mk(1, 0, 0, 4'h0, 0, 4'h0, 1, 0, 0, 4'h0));
      tbl.push_back(mk(0, 1, 1, 4'h0, 0, 4'h0, 0, 1, 0, 4'h0));
      tbl.push_back(mk(0, 0, 1, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0));
      tbl.push_back(mk(0, 1, 3, 4'h0, 1, 4'h1, 0, 0, 1, 4'h0));

      // reset values while rst is held
      tick();
      chk("rst.a_state", a_state, 4'h1);
      chk("rst.b_state", b_state, 16'hFFFF);
      chk("rst.b_dout", b_dout, 8'h00);
      chk("rst.b_valid", b_valid, 1'b0);
      chk("rst.b_lock", b_lock, 1'b0);
      chk("rst.b_err", b_err, 16'h0);
      rst = 1'b0;
      tick();

      // directed table on the 4-bit instance
      visited = '0;
      for (int i = 0; i < tbl.size(); i++) begin
         a_load = tbl[i].ld; a_en = tbl[i].en; a_mode = tbl[i].md;
         a_seed = tbl[i].sd; a_din = tbl[i].di;
         tick();
         if (i >= 1 && i <= 15) visited[a_state] = 1'b1;
         chk($sformatf("vec%0d.state", i), a_state, tbl[i].e_state);
         chk($sformatf("vec%0d.dout", i), a_dout, tbl[i].e_dout);
         chk($sformatf("vec%0d.valid", i), a_valid, tbl[i].e_valid);
         chk($sformatf("vec%0d.lockup", i), a_lock, tbl[i].e_lock);
         chk($sformatf("vec%0d.err", i), a_err, tbl[i].e_err);
      end
      a_load = 0; a_en = 0;
      chk("gen.visited", visited, 16'hFFFE);

      // CHECK mode against a reference PRBS with three inverted bits
      a_load = 1; a_seed = 4'h1; tick(); a_load = 0;
      ms = 1; a_mode = 2'd3; a_en = 1;
      for (int i = 0; i < 100; i++) begin
         ms = mstep(ms, 4, 32'h3, 1'b0, o);
         a_din = o ^ (i == 10 || i == 50 || i == 90);
         tick();
      end
      a_en = 0; tick();
      chk("chk3.err", a_err, 4'd3);
      chk("chk3.state", a_state, ms[3:0]);

      // saturation with a 4-bit counter
      a_load = 1; a_seed = 4'h1; tick(); a_load = 0;
      chk("sat.cleared", a_err, 4'd0);
      ms = 1; a_en = 1;
      for (int i = 0; i < 40; i++) begin
         ms = mstep(ms, 4, 32'h3, 1'b0, o);
         a_din = o ^ (i % 2 == 0);
         tick();
      end
      chk("sat.20err", a_err, 4'd15);
      for (int i = 0; i < 10; i++) begin
         ms = mstep(ms, 4, 32'h3, 1'b0, o);
         a_din = ~o;
         tick();
      end
      a_en = 0;
      chk("sat.held", a_err, 4'd15);

      // CRC-16/CCITT over "123456789"
      b_load = 1; b_seed = 16'hFFFF; tick(); b_load = 0;
      b_mode = 2'd1; b_en = 1;
      for (int i = 0; i < 9; i++) begin
         b_din = 8'h31 + 8'(i);
         tick();
      end
      chk("crc.valid", b_valid, 1'b1);
      chk("crc.result", b_state, 16'h29B1);
      b_en = 0; tick();
      chk("crc.valid_drop", b_valid, 1'b0);

      // lockup in GEN recovers; in CRC a zero state is kept
      b_load = 1; b_seed = 16'h0; tick(); b_load = 0;
      b_mode = 2'd0; b_en = 1; tick(); b_en = 0;
      chk("lock.gen_state", b_state, 16'hFFFF);
      chk("lock.gen_pulse", b_lock, 1'b1);
      chk("lock.gen_valid", b_valid, 1'b0);
      tick();
      chk("lock.gen_pulse_end", b_lock, 1'b0);
      b_load = 1; b_seed = 16'h0; tick(); b_load = 0;
      b_mode = 2'd1; b_din = 8'h00; b_en = 1; tick(); b_en = 0;
      chk("lock.crc_state", b_state, 16'h0);
      chk("lock.crc_pulse", b_lock, 1'b0);
      chk("lock.crc_valid", b_valid, 1'b1);

      // scramble a 32-bit word, then descramble with the same seed
      pat = 32'hDEADBEEF;
      for (int pass = 0; pass < 2; pass++) begin
         c_load = 1; c_seed = 16'hACE1; tick(); c_load = 0;
         c_mode = 2'd2; ms = 16'hACE1; exp_nib = '0;
         for (int n = 0; n < 8; n++) begin
            c_din = (pass == 0) ? pat[31-4*n -: 4] : scr[31-4*n -: 4];
            for (int k = 0; k < 4; k++) begin
               ms = mstep(ms, 16, 32'h1021, 1'b0, o);
               exp_nib[3-k] = c_din[3-k] ^ o;
            end
            c_en = 1; tick(); c_en = 0;
            chk($sformatf("scr%0d.n%0d.dout", pass, n), c_dout, exp_nib);
            chk($sformatf("scr%0d.n%0d.valid", pass, n), c_valid, 1'b1);
            if (pass == 0) scr[31-4*n -: 4] = c_dout;
            else           rec[31-4*n -: 4] = c_dout;
            if (n == 3) begin
               tick();
               chk($sformatf("scr%0d.gap.valid", pass), c_valid, 1'b0);
               chk($sformatf("scr%0d.gap.dout", pass), c_dout, exp_nib);
            end
         end
      end
      chk("scr.roundtrip", rec, pat);

      // randomized run against the reference model
      m_st = 16'hFFFF; m_err = 0; m_dout = b_dout; m_valid = 0; m_lock = 0;
      b_load = 1; b_seed = 16'hFFFF; b_en = 0; tick();
      for (int cyc = 0; cyc < 500; cyc++) begin
         int mis;
         bit bi;
         b_load = ($urandom % 16) == 0;
         b_seed = (($urandom % 3) == 0) ? 16'h0 : 16'($urandom);
         b_en   = ($urandom % 4) != 0;
         b_mode = 2'($urandom);
         b_din  = 8'($urandom);
         if (b_load) begin
            m_st = b_seed; m_err = 0; m_valid = 0; m_lock = 0;
         end else if (b_en && m_st == 0 && b_mode != 2'd1) begin
            m_st = 16'hFFFF; m_lock = 1; m_valid = 0;
         end else if (b_en) begin
            mis = 0;
            for (int k = 0; k < 8; k++) begin
               bi = b_din[7-k];
               ms = mstep(32'(m_st), 16, 32'h1021, (b_mode == 2'd1) ? bi : 1'b0, o);
               m_st = ms[15:0];
               m_dout[7-k] = (b_mode == 2'd2) ? (bi ^ o) : o;
               if (b_mode == 2'd3 && bi != o) mis++;
            end
            m_err = (m_err + mis > 65535) ? 65535 : m_err + mis;
            m_valid = 1; m_lock = 0;
         end else begin
            m_valid = 0; m_lock = 0;
         end
         tick();
         n_tests++;
         if (b_state !== m_st || b_dout !== m_dout || b_valid !== m_valid ||
             b_lock !== m_lock || b_err !== m_err[15:0]) begin
            n_fail++;
            $display("FAIL rand%0d: got st=%h do=%h v=%b l=%b e=%0d, expected st=%h do=%h v=%b l=%b e=%0d",
                     cyc, b_state, b_dout, b_valid, b_lock, b_err,
                     m_st, m_dout, m_valid, m_lock, m_err);
         end
      end
      b_load = 0; b_en = 0;

      // asynchronous reset in the middle of a CRC run
      b_load = 1; b_seed = 16'hACE1; tick(); b_load = 0;
      b_mode = 2'd1; b_en = 1;
      for (int i = 0; i < 3; i++) begin
         b_din = 8'hA5 ^ 8'(i);
         tick();
      end
      rst = 1'b1;
      #1;
      chk("arst.state", b_state, 16'hFFFF);
      chk("arst.valid", b_valid, 1'b0);
      chk("arst.dout", b_dout, 8'h00);
      #1 rst = 1'b0;
      b_en = 0;
      tick();
      chk("arst.after", b_state, 16'hFFFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
